// File: rtl/rob.sv
// Reorder buffer: circular queue that allocates, collects CDB results and retires in program order.
// Latency: alloc ID is available combinationally; a CDB write commits no earlier than the next cycle.
// Backpressure: alloc_ready drops when full or flushing; decode holds its request until accepted.
module rob #(
    parameter int ROB_DEPTH_BITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    // allocation from decode
    input  logic                      alloc_valid,
    input  logic [4:0]                alloc_rd_addr,
    output logic                      alloc_ready,
    output logic [ROB_DEPTH_BITS-1:0] alloc_rob_id,
    // common data bus
    input  logic                      cdb_valid,
    input  logic [ROB_DEPTH_BITS-1:0] cdb_rob_id,
    input  logic [31:0]               cdb_data,
    input  logic                      cdb_mispredict,
    // in-order retirement to the register file
    output logic                      commit_valid,
    output logic [4:0]                commit_rd_addr,
    output logic [31:0]               commit_rd_data,
    output logic [ROB_DEPTH_BITS-1:0] commit_rob_id,
    output logic                      flush,
    // operand lookup from dispatch
    input  logic [ROB_DEPTH_BITS-1:0] rs1_rob_id,
    input  logic [ROB_DEPTH_BITS-1:0] rs2_rob_id,
    output logic                      rs1_rob_ready,
    output logic                      rs2_rob_ready,
    output logic [31:0]               rs1_rob_data,
    output logic [31:0]               rs2_rob_data,
    // occupancy
    output logic                      empty,
    output logic                      full
);

    localparam int DEPTH = 1 << ROB_DEPTH_BITS;

    // Constants sized to the pointer and counter widths so arithmetic stays width-exact.
    localparam logic [ROB_DEPTH_BITS-1:0] ID_ONE    = {{(ROB_DEPTH_BITS-1){1'b0}}, 1'b1};
    localparam logic [ROB_DEPTH_BITS:0]   CNT_ONE   = {{ROB_DEPTH_BITS{1'b0}}, 1'b1};
    localparam logic [ROB_DEPTH_BITS:0]   CNT_DEPTH = {1'b1, {ROB_DEPTH_BITS{1'b0}}};

    // Per-entry state. Control bits are packed vectors; payloads are unpacked arrays.
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q,  done_d;
    logic [DEPTH-1:0] mispred_q, mispred_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];

    // Pointers wrap naturally because they are exactly ROB_DEPTH_BITS wide.
    logic [ROB_DEPTH_BITS-1:0] head_q, head_d;
    logic [ROB_DEPTH_BITS-1:0] tail_q, tail_d;
    logic [ROB_DEPTH_BITS:0]   count_q, count_d;

    logic alloc_fire;
    logic commit_fire;
    logic cdb_hit;

    // Status, handshake and commit outputs, all derived from stored state (no CDB-to-commit path).
    always_comb begin
        full           = (count_q == CNT_DEPTH);
        empty          = (count_q == '0);
        commit_valid   = valid_q[head_q] && done_q[head_q];
        commit_rd_addr = rd_q[head_q];
        commit_rd_data = data_q[head_q];
        commit_rob_id  = head_q;
        flush          = commit_valid && mispred_q[head_q];
        // A full ROB refuses allocation even when the head retires this cycle.
        alloc_ready    = !full && !flush;
        alloc_rob_id   = tail_q;
        alloc_fire     = alloc_valid && alloc_ready;
        commit_fire    = commit_valid;
        // Results for entries that are not live (stale or flushed IDs) are dropped.
        cdb_hit        = cdb_valid && valid_q[cdb_rob_id];
    end

    // rs1 lookup: same-cycle CDB bypass wins over stored data; nothing is ready while flushing.
    always_comb begin
        rs1_rob_ready = 1'b0;
        rs1_rob_data  = data_q[rs1_rob_id];
        if (cdb_valid && (cdb_rob_id == rs1_rob_id)) begin
            rs1_rob_ready = 1'b1;
            rs1_rob_data  = cdb_data;
        end else if (valid_q[rs1_rob_id] && done_q[rs1_rob_id]) begin
            rs1_rob_ready = 1'b1;
        end
        if (flush) begin
            rs1_rob_ready = 1'b0;
        end
    end

    // rs2 lookup: identical to rs1.
    always_comb begin
        rs2_rob_ready = 1'b0;
        rs2_rob_data  = data_q[rs2_rob_id];
        if (cdb_valid && (cdb_rob_id == rs2_rob_id)) begin
            rs2_rob_ready = 1'b1;
            rs2_rob_data  = cdb_data;
        end else if (valid_q[rs2_rob_id] && done_q[rs2_rob_id]) begin
            rs2_rob_ready = 1'b1;
        end
        if (flush) begin
            rs2_rob_ready = 1'b0;
        end
    end

    // Next-state: a flush discards everything (including this cycle's alloc and CDB);
    // otherwise apply writeback, allocation and commit in that order.
    always_comb begin
        valid_d   = valid_q;
        done_d    = done_q;
        mispred_d = mispred_q;
        rd_d      = rd_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (flush) begin
            valid_d   = '0;
            done_d    = '0;
            mispred_d = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end else begin
            if (cdb_hit) begin
                done_d[cdb_rob_id]    = 1'b1;
                data_d[cdb_rob_id]    = cdb_data;
                mispred_d[cdb_rob_id] = cdb_mispredict;
            end

            // The tail entry is never live when alloc fires, so this cannot collide with the CDB write.
            if (alloc_fire) begin
                valid_d[tail_q]   = 1'b1;
                done_d[tail_q]    = 1'b0;
                mispred_d[tail_q] = 1'b0;
                rd_d[tail_q]      = alloc_rd_addr;
                tail_d            = tail_q + ID_ONE;
            end

            if (commit_fire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + ID_ONE;
            end

            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            done_q    <= '0;
            mispred_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            done_q    <= done_d;
            mispred_q <= mispred_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer: reset, in-order commit, full, flush, wrap, bypass, alloc+commit.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
// All expected values are hand-derived constants or loop-index expressions.
module tb_rob;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic [4:0]  alloc_rd_addr;
    logic        alloc_ready;
    logic [3:0]  alloc_rob_id;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_data;
    logic        cdb_mispredict;
    logic        commit_valid;
    logic [4:0]  commit_rd_addr;
    logic [31:0] commit_rd_data;
    logic [3:0]  commit_rob_id;
    logic        flush;
    logic [3:0]  rs1_rob_id;
    logic [3:0]  rs2_rob_id;
    logic        rs1_rob_ready;
    logic        rs2_rob_ready;
    logic [31:0] rs1_rob_data;
    logic [31:0] rs2_rob_data;
    logic        empty;
    logic        full;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rob #(.ROB_DEPTH_BITS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_rd_addr  (alloc_rd_addr),
        .alloc_ready    (alloc_ready),
        .alloc_rob_id   (alloc_rob_id),
        .cdb_valid      (cdb_valid),
        .cdb_rob_id     (cdb_rob_id),
        .cdb_data       (cdb_data),
        .cdb_mispredict (cdb_mispredict),
        .commit_valid   (commit_valid),
        .commit_rd_addr (commit_rd_addr),
        .commit_rd_data (commit_rd_data),
        .commit_rob_id  (commit_rob_id),
        .flush          (flush),
        .rs1_rob_id     (rs1_rob_id),
        .rs2_rob_id     (rs2_rob_id),
        .rs1_rob_ready  (rs1_rob_ready),
        .rs2_rob_ready  (rs2_rob_ready),
        .rs1_rob_data   (rs1_rob_data),
        .rs2_rob_data   (rs2_rob_data),
        .empty          (empty),
        .full           (full)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        alloc_valid    = 1'b0;
        alloc_rd_addr  = 5'd0;
        cdb_valid      = 1'b0;
        cdb_rob_id     = 4'd0;
        cdb_data       = 32'd0;
        cdb_mispredict = 1'b0;
    endtask

    // Reset is held with live alloc/CDB traffic to show it takes priority.
    task automatic do_reset();
        rst            = 1'b1;
        alloc_valid    = 1'b1;
        alloc_rd_addr  = 5'd7;
        cdb_valid      = 1'b1;
        cdb_rob_id     = 4'd0;
        cdb_data       = 32'hDEAD;
        cdb_mispredict = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle();
    endtask

    task automatic alloc_one(input logic [4:0] rd);
        alloc_valid   = 1'b1;
        alloc_rd_addr = rd;
        tick();
        idle();
    endtask

    task automatic cdb_one(input logic [3:0] id, input logic [31:0] dat, input logic mp);
        cdb_valid      = 1'b1;
        cdb_rob_id     = id;
        cdb_data       = dat;
        cdb_mispredict = mp;
        tick();
        idle();
    endtask

    initial begin
        rs1_rob_id = 4'd0;
        rs2_rob_id = 4'd0;
        idle();

        // ---------------- reset, allocate, commit in order ----------------
        do_reset();
        settle();
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_id", alloc_rob_id, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rs1_ready", rs1_rob_ready, 0);
        chk("rst_rs2_ready", rs2_rob_ready, 0);

        for (int k = 1; k <= 3; k++) begin
            alloc_valid   = 1'b1;
            alloc_rd_addr = 5'(k);
            settle();
            chk("t1_alloc_id", alloc_rob_id, k - 1);
            tick();
        end
        idle();
        cdb_one(4'd2, 32'h22, 1'b0);
        settle();
        chk("t1_no_commit_before_id0", commit_valid, 0);
        rs1_rob_id = 4'd2;
        settle();
        chk("t1_rs1_ready_stored", rs1_rob_ready, 1);
        chk("t1_rs1_data_stored", rs1_rob_data, 32'h22);
        cdb_one(4'd0, 32'h00, 1'b0);
        // ID 1's writeback lands in the same cycle that ID 0 retires.
        cdb_valid  = 1'b1;
        cdb_rob_id = 4'd1;
        cdb_data   = 32'h11;
        settle();
        chk("t1_c0_valid", commit_valid, 1);
        chk("t1_c0_id", commit_rob_id, 0);
        chk("t1_c0_rd", commit_rd_addr, 1);
        chk("t1_c0_data", commit_rd_data, 32'h00);
        tick();
        idle();
        settle();
        chk("t1_c1_valid", commit_valid, 1);
        chk("t1_c1_id", commit_rob_id, 1);
        chk("t1_c1_rd", commit_rd_addr, 2);
        chk("t1_c1_data", commit_rd_data, 32'h11);
        tick();
        settle();
        chk("t1_c2_valid", commit_valid, 1);
        chk("t1_c2_id", commit_rob_id, 2);
        chk("t1_c2_rd", commit_rd_addr, 3);
        chk("t1_c2_data", commit_rd_data, 32'h22);
        tick();
        settle();
        chk("t1_final_commit_valid", commit_valid, 0);
        chk("t1_final_empty", empty, 1);

        // ---------------- full boundary ----------------
        do_reset();
        for (int k = 0; k < 16; k++) begin
            alloc_one(5'(k));
        end
        settle();
        chk("t2_full", full, 1);
        chk("t2_alloc_ready", alloc_ready, 0);
        chk("t2_tail", alloc_rob_id, 0);
        chk("t2_count", dut.count_q, 16);
        chk("t2_empty", empty, 0);
        alloc_valid   = 1'b1;
        alloc_rd_addr = 5'd31;
        tick();
        settle();
        chk("t2_17th_tail", alloc_rob_id, 0);
        chk("t2_17th_count", dut.count_q, 16);
        cdb_valid  = 1'b1;
        cdb_rob_id = 4'd0;
        cdb_data   = 32'h77;
        tick();
        cdb_valid = 1'b0;
        settle();
        chk("t2_head_commit", commit_valid, 1);
        chk("t2_still_full", full, 1);
        chk("t2_refuse_while_commit", alloc_ready, 0);
        tick();
        settle();
        chk("t2_ready_after_commit", alloc_ready, 1);
        chk("t2_not_full", full, 0);
        chk("t2_count_15", dut.count_q, 15);
        chk("t2_head_1", commit_rob_id, 1);
        tick();
        idle();
        settle();
        chk("t2_refill_full", full, 1);
        chk("t2_refill_tail", alloc_rob_id, 1);

        // ---------------- mispredict flush ----------------
        do_reset();
        for (int k = 0; k < 5; k++) begin
            alloc_one(5'(k + 5));
        end
        cdb_one(4'd0, 32'h55, 1'b1);
        alloc_valid   = 1'b1;
        alloc_rd_addr = 5'd20;
        cdb_valid     = 1'b1;
        cdb_rob_id    = 4'd1;
        cdb_data      = 32'h99;
        rs1_rob_id    = 4'd1;
        settle();
        chk("t3_commit_valid", commit_valid, 1);
        chk("t3_flush", flush, 1);
        chk("t3_commit_rd", commit_rd_addr, 5);
        chk("t3_commit_data", commit_rd_data, 32'h55);
        chk("t3_alloc_ready_low", alloc_ready, 0);
        chk("t3_rs1_blocked", rs1_rob_ready, 0);
        tick();
        idle();
        settle();
        chk("t3_flush_one_cycle", flush, 0);
        chk("t3_empty", empty, 1);
        chk("t3_tail_zero", alloc_rob_id, 0);
        chk("t3_alloc_ready_back", alloc_ready, 1);
        chk("t3_count_zero", dut.count_q, 0);
        for (int j = 1; j <= 4; j++) begin
            cdb_one(4'(j), 32'(j), 1'b0);
        end
        settle();
        chk("t3_late_wb_no_commit", commit_valid, 0);
        chk("t3_late_wb_empty", empty, 1);
        chk("t3_late_wb_lookup", rs1_rob_ready, 0);

        // ---------------- wrap-around ----------------
        do_reset();
        for (int i = 0; i < 20; i++) begin
            alloc_valid   = 1'b1;
            alloc_rd_addr = 5'(i + 1);
            settle();
            chk("t4_alloc_id", alloc_rob_id, i % 16);
            tick();
            idle();
            cdb_one(4'(i), 32'h1000 + i, 1'b0);
            settle();
            chk("t4_commit_valid", commit_valid, 1);
            chk("t4_commit_id", commit_rob_id, i % 16);
            chk("t4_commit_rd", commit_rd_addr, i + 1);
            chk("t4_commit_data", commit_rd_data, 32'h1000 + i);
            tick();
            settle();
            chk("t4_empty", empty, 1);
            chk("t4_count_bound", 32'(dut.count_q <= 5'd16), 1);
        end

        // ---------------- lookup bypass ----------------
        do_reset();
        for (int k = 0; k < 4; k++) begin
            alloc_one(5'(k + 1));
        end
        rs1_rob_id = 4'd3;
        rs2_rob_id = 4'd2;
        cdb_valid  = 1'b1;
        cdb_rob_id = 4'd3;
        cdb_data   = 32'hABCD;
        settle();
        chk("t5_rs1_bypass_ready", rs1_rob_ready, 1);
        chk("t5_rs1_bypass_data", rs1_rob_data, 32'hABCD);
        chk("t5_rs2_not_ready", rs2_rob_ready, 0);
        tick();
        idle();
        settle();
        chk("t5_rs1_stored_ready", rs1_rob_ready, 1);
        chk("t5_rs1_stored_data", rs1_rob_data, 32'hABCD);
        cdb_valid  = 1'b1;
        cdb_rob_id = 4'd2;
        cdb_data   = 32'h1234;
        settle();
        chk("t5_rs2_bypass_ready", rs2_rob_ready, 1);
        chk("t5_rs2_bypass_data", rs2_rob_data, 32'h1234);
        tick();
        idle();

        // ---------------- simultaneous allocate and commit ----------------
        do_reset();
        for (int k = 0; k < 8; k++) begin
            alloc_one(5'(k + 1));
        end
        cdb_one(4'd0, 32'h5, 1'b0);
        settle();
        chk("t6_count_before", dut.count_q, 8);
        chk("t6_commit_valid", commit_valid, 1);
        chk("t6_head_before", commit_rob_id, 0);
        chk("t6_tail_before", alloc_rob_id, 8);
        alloc_valid   = 1'b1;
        alloc_rd_addr = 5'd9;
        tick();
        idle();
        settle();
        chk("t6_count_after", dut.count_q, 8);
        chk("t6_head_after", commit_rob_id, 1);
        chk("t6_tail_after", alloc_rob_id, 9);
        chk("t6_next_not_done", commit_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
